// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: processes one bit per clock, LSB first, and
// publishes sum/cout/ovf only when the whole word has been processed.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [1:0]       fsm_state
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    // Handshake: start is accepted on any rising edge where busy is low
    // (IDLE or DONE); while busy is high start is ignored, never queued.

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             bit_s;
    logic             bit_c;
    logic             accept;
    logic             last_bit;

    always_comb begin
        bit_s    = a_sh[0] ^ b_sh[0] ^ carry;
        bit_c    = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
        accept   = start && (state != RUN);
        last_bit = (state == RUN) && (cnt == LAST);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = RUN;
            RUN:     if (cnt == LAST) state_nx = DONE;
            DONE:    state_nx = accept ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Subtraction is a + ~b + 1, so the mode only shapes the captured
    // operand and the initial carry; the datapath itself is always an adder.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= sub ? ~b : b;
            carry  <= sub ? 1'b1 : cin;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= {bit_s, res_sh[WIDTH-1:1]};
            carry  <= bit_c;
            cnt    <= cnt + 1'b1;
        end
    end

    // The visible result is loaded only on the final bit so partial sums
    // held in res_sh never reach the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else if (last_bit) begin
            sum  <= {bit_s, res_sh[WIDTH-1:1]};
            cout <= bit_c;
            ovf  <= carry ^ bit_c;
        end
    end

    always_comb begin
        busy      = (state == RUN);
        done      = (state == DONE);
        fsm_state = state;
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for the main scenarios
// and a 2-bit instance swept exhaustively against an arithmetic model.
module tb_serial_adder;

    logic       clk;
    logic       rst;

    logic       start8, sub8, cin8;
    logic [7:0] a8, b8;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] sum8;
    logic [1:0] st8;

    logic       start2, sub2, cin2;
    logic [1:0] a2, b2;
    logic       busy2, done2, cout2, ovf2;
    logic [1:0] sum2;
    logic [1:0] st2;

    int checks;
    int failures;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .cin(cin8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .sum(sum8),
        .cout(cout8), .ovf(ovf8), .fsm_state(st8)
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .sub(sub2), .cin(cin2),
        .a(a2), .b(b2), .busy(busy2), .done(done2), .sum(sum2),
        .cout(cout2), .ovf(ovf2), .fsm_state(st2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Driver: called at a falling edge; returns at the falling edge where done
    // is seen (or after the cycle budget). wait_n counts falling edges from
    // the one after the accepting edge, so done should appear at wait_n = 9.
    task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic is,
                       input logic ic, output int busy_n, output int wait_n);
        a8 = ia; b8 = ib; sub8 = is; cin8 = ic; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); sub8 = ~is; cin8 = ~ic;
        busy_n = 0;
        wait_n = 1;
        while (done8 !== 1'b1 && wait_n < 40) begin
            if (busy8 === 1'b1) busy_n++;
            @(negedge clk);
            wait_n++;
        end
    endtask

    task automatic op2(input logic [1:0] ia, input logic [1:0] ib, input logic ic,
                       output int wait_n);
        a2 = ia; b2 = ib; sub2 = 1'b0; cin2 = ic; start2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start2 = 1'b0;
        a2 = 2'($urandom); b2 = 2'($urandom); cin2 = ~ic;
        wait_n = 1;
        while (done2 !== 1'b1 && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        start2 = 1'b0; sub2 = 1'b0; cin2 = 1'b0; a2 = 2'b00; b2 = 2'b00;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy8, done8, cout8, ovf8, sum8, st8} !== 14'h0) begin
            failures++;
            $display("FAIL reset8 got busy=%b done=%b cout=%b ovf=%b sum=%h st=%0d exp all 0",
                     busy8, done8, cout8, ovf8, sum8, st8);
        end
        checks++;
        if ({busy2, done2, cout2, ovf2, sum2, st2} !== 8'h0) begin
            failures++;
            $display("FAIL reset2 got busy=%b done=%b cout=%b ovf=%b sum=%h st=%0d exp all 0",
                     busy2, done2, cout2, ovf2, sum2, st2);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_table(input string name, input logic [7:0] ta[4], input logic [7:0] tb[4],
                             input logic tsub, input logic tc[4], input logic [9:0] texp[4]);
        int busy_n, wait_n;
        for (int i = 0; i < 4; i++) begin
            op8(ta[i], tb[i], tsub, tc[i], busy_n, wait_n);
            checks++;
            if (wait_n != 9 || busy_n != 8) begin
                failures++;
                $display("FAIL %s_latency[%0d] got done_at=%0d busy_cycles=%0d exp 9 and 8",
                         name, i, wait_n, busy_n);
            end
            checks++;
            if ({cout8, ovf8, sum8} !== texp[i]) begin
                failures++;
                $display("FAIL %s_result[%0d] got cout=%b ovf=%b sum=%h exp cout=%b ovf=%b sum=%h",
                         name, i, cout8, ovf8, sum8, texp[i][9], texp[i][8], texp[i][7:0]);
            end
            @(negedge clk);
            checks++;
            if (done8 !== 1'b0 || busy8 !== 1'b0 || {cout8, ovf8, sum8} !== texp[i]) begin
                failures++;
                $display("FAIL %s_hold[%0d] got done=%b busy=%b sum=%h exp done=0 busy=0 sum=%h",
                         name, i, done8, busy8, sum8, texp[i][7:0]);
            end
        end
    endtask

    task automatic test_add();
        logic [7:0] ta[4]   = '{8'h00, 8'hFF, 8'h7F, 8'h3C};
        logic [7:0] tb[4]   = '{8'h00, 8'h01, 8'h01, 8'h45};
        logic       tc[4]   = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [9:0] texp[4] = '{{2'b00, 8'h00}, {2'b10, 8'h00}, {2'b01, 8'h80}, {2'b01, 8'h82}};
        run_table("add", ta, tb, 1'b0, tc, texp);
    endtask

    task automatic test_sub();
        logic [7:0] ta[4]   = '{8'h05, 8'h80, 8'h10, 8'h01};
        logic [7:0] tb[4]   = '{8'h07, 8'h01, 8'h10, 8'h00};
        logic       tc[4]   = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [9:0] texp[4] = '{{2'b00, 8'hFE}, {2'b11, 8'h7F}, {2'b10, 8'h00}, {2'b10, 8'h01}};
        run_table("sub", ta, tb, 1'b1, tc, texp);
    endtask

    task automatic test_back_to_back();
        int   busy_n, wait_n, j;
        logic partial_ok;
        op8(8'hAA, 8'h11, 1'b0, 1'b0, busy_n, wait_n);
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; sub8 = 1'b0; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        j = 0;
        partial_ok = 1'b1;
        while (done8 !== 1'b1 && j < 40) begin
            if (sum8 !== 8'hBB) partial_ok = 1'b0;
            if (j == 2) begin
                start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1; cin8 = 1'b1;
            end
            if (j == 4) start8 = 1'b0;
            @(negedge clk);
            j++;
        end
        checks++;
        if (j != 8) begin
            failures++;
            $display("FAIL ignore_timing got done_at=%0d exp 8", j);
        end
        checks++;
        if ({cout8, ovf8, sum8} !== {2'b00, 8'h46}) begin
            failures++;
            $display("FAIL ignore_result got cout=%b ovf=%b sum=%h exp cout=0 ovf=0 sum=46",
                     cout8, ovf8, sum8);
        end
        checks++;
        if (partial_ok !== 1'b1) begin
            failures++;
            $display("FAIL no_partial got sum changed during run exp held at bb");
        end
        // Start presented in the DONE cycle itself.
        a8 = 8'h05; b8 = 8'h07; sub8 = 1'b1; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        j = 1;
        while (done8 !== 1'b1 && j < 40) begin
            @(negedge clk);
            j++;
        end
        checks++;
        if (j != 9) begin
            failures++;
            $display("FAIL b2b_timing got done_after=%0d exp 9", j);
        end
        checks++;
        if ({cout8, ovf8, sum8} !== {2'b00, 8'hFE}) begin
            failures++;
            $display("FAIL b2b_result got cout=%b ovf=%b sum=%h exp cout=0 ovf=0 sum=fe",
                     cout8, ovf8, sum8);
        end
        @(negedge clk);
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || st8 !== 2'd0) begin
            failures++;
            $display("FAIL b2b_idle got busy=%b done=%b st=%0d exp 0 0 0", busy8, done8, st8);
        end
    endtask

    task automatic test_reset_mid_run();
        int   busy_n, wait_n;
        logic saw_done;
        a8 = 8'h12; b8 = 8'h34; sub8 = 1'b0; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({busy8, done8, cout8, ovf8, sum8, st8} !== 14'h0) begin
            failures++;
            $display("FAIL midrun_reset got busy=%b done=%b cout=%b ovf=%b sum=%h st=%0d exp all 0",
                     busy8, done8, cout8, ovf8, sum8, st8);
        end
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done8 === 1'b1 || sum8 !== 8'h00) saw_done = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (saw_done !== 1'b0) begin
            failures++;
            $display("FAIL midrun_no_done got done or result after abort exp none");
        end
        op8(8'h21, 8'h43, 1'b0, 1'b0, busy_n, wait_n);
        checks++;
        if (wait_n != 9) begin
            failures++;
            $display("FAIL post_reset_latency got done_at=%0d exp 9", wait_n);
        end
        checks++;
        if ({cout8, ovf8, sum8} !== {2'b00, 8'h64}) begin
            failures++;
            $display("FAIL post_reset_result got cout=%b ovf=%b sum=%h exp cout=0 ovf=0 sum=64",
                     cout8, ovf8, sum8);
        end
        @(negedge clk);
    endtask

    task automatic test_width2();
        int         wait_n;
        logic [2:0] tot;
        logic       exp_ovf;
        for (int ia = 0; ia < 4; ia++) begin
            for (int ib = 0; ib < 4; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    op2(2'(ia), 2'(ib), 1'(ic), wait_n);
                    tot = 3'(ia) + 3'(ib) + 3'(ic);
                    exp_ovf = (ia[1] == ib[1]) && (tot[1] != ia[1]);
                    checks++;
                    if (wait_n != 3) begin
                        failures++;
                        $display("FAIL w2_latency a=%0d b=%0d c=%0d got done_at=%0d exp 3",
                                 ia, ib, ic, wait_n);
                    end
                    checks++;
                    if ({cout2, sum2} !== tot) begin
                        failures++;
                        $display("FAIL w2_sum a=%0d b=%0d c=%0d got %0d exp %0d",
                                 ia, ib, ic, {cout2, sum2}, tot);
                    end
                    checks++;
                    if (ovf2 !== exp_ovf) begin
                        failures++;
                        $display("FAIL w2_ovf a=%0d b=%0d c=%0d got %b exp %b",
                                 ia, ib, ic, ovf2, exp_ovf);
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_reset_mid_run();
        test_width2();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..64.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin an operation; sampled on rising clk.
REQ-005 sub  input  1  mode: 0 = add, 1 = subtract (a - b); captured with start.
REQ-006 cin  input  1  carry-in for add mode; ignored in subtract mode.
REQ-007 a  input  WIDTH  operand A, unsigned or two's complement.
REQ-008 b  input  WIDTH  operand B, unsigned or two's complement.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse marking that the result is valid.
REQ-011 sum  output  WIDTH  result word.
REQ-012 cout  output  1  final carry out of the MSB; in subtract mode 1 = no borrow (a >= b unsigned).
REQ-013 ovf  output  1  signed overflow, equal to carry into MSB XOR carry out of MSB.

Function
REQ-014 The block SHALL use a three-state FSM: IDLE, RUN, DONE.
REQ-015 A start SHALL be accepted when busy=0, i.e. in IDLE or DONE.
REQ-016 On acceptance, the block SHALL capture a, b and sub into internal shift/mode registers, clear the bit counter and enter RUN.
REQ-017 On acceptance, the carry flop SHALL load cin in add mode and 1 in subtract mode.
REQ-018 In subtract mode, b SHALL be bitwise inverted at capture.
REQ-019 In RUN, each clock SHALL process exactly one bit, LSB first, using a one-bit full-adder sum/carry equation on a[i], b'[i] and the carry flop.
REQ-020 In RUN, each clock SHALL shift the sum bit into the result register and update the carry flop.
REQ-021 busy SHALL equal 1 exactly while state = RUN.
REQ-022 Latency: for start accepted at edge k, RUN SHALL occupy edges k+1..k+WIDTH; DONE SHALL be entered at edge k+WIDTH.
REQ-023 done SHALL be high for exactly the one cycle after edge k+WIDTH, after which the FSM returns to IDLE unless a new start is accepted.
REQ-024 sum, cout and ovf SHALL update only at the transition into DONE, then hold until the next transition into DONE or until reset.
REQ-025 Intermediate partial sums SHALL never appear on sum.
REQ-026 A start asserted while busy=1 SHALL be ignored: no re-capture, no state change, no queuing.
REQ-027 A start accepted in DONE SHALL begin a back-to-back operation with no idle cycle; done still pulses for the completing result in that cycle.
REQ-028 Operands may change after acceptance without affecting the result.
REQ-029 Arithmetic SHALL be modulo 2^WIDTH, with carry and overflow reported only via cout and ovf.

Reset
REQ-030 While rst=1, the FSM SHALL be IDLE, and busy, done, sum, cout, ovf, the carry flop, the counter and the shift registers SHALL all be 0.
REQ-031 Reset asserted mid-RUN SHALL abort the operation with no done pulse and no result update.
REQ-032 The first start after rst deasserts SHALL be accepted on the first rising clk that samples it.

Verification (WIDTH=8 unless stated)
REQ-033 Add, a=0x00, b=0x00, cin=0 -> after 8 busy cycles, done pulse with sum=0x00, cout=0, ovf=0.
REQ-034 Add, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; and a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1.
REQ-035 Subtract, a=0x05, b=0x07 -> sum=0xFE, cout=0, ovf=0; and a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
REQ-036 start re-pulsed with different operands during RUN -> ignored; the original result is produced at the original time. Then back-to-back start in the DONE cycle -> next done exactly 9 cycles later.
REQ-037 rst pulsed after 4 RUN cycles -> busy=0, done never pulses, sum/cout/ovf=0; a subsequent normal operation produces the correct result.
REQ-038 WIDTH=2, all 32 combinations of a, b, cin in add mode -> {cout,sum} = a+b+cin for every case, checked against a reference model.
